// File: rtl/ysyx_20020207_ifu.sv
// Instruction fetch unit: one AR/R read per fetch, result handed to the decoder over valid/ready.
// Latency: 3 cycles trigger-to-inst_valid with zero-wait memory; 1 cycle for a misaligned pc.
// Backpressure: holds arvalid until arready, holds inst/inst_pc/fetch_err until inst_ready; fetch_en outside IDLE is dropped.
// Optional: define IFU_PERF_CNT_EN to add perf_fetch_cnt / perf_stall_cnt outputs.
module ysyx_20020207_ifu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [DATA_WIDTH-1:0] araddr,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  fetch_err,
    output logic                  busy
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0] state;
    logic       boot;

    // Handshake outputs are pure functions of state so they are glitch-free and reset with it.
    assign arvalid    = (state == S_REQ);
    assign rready     = (state == S_WAIT);
    assign inst_valid = (state == S_OUT);
    assign busy       = (state != S_IDLE);

    // Fetch FSM with its latched address, instruction and error qualifier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            boot      <= 1'b1;
            araddr    <= '0;
            inst      <= '0;
            inst_pc   <= '0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // boot forces the very first fetch after reset without a trigger.
                    if (fetch_en || boot) begin
                        boot    <= 1'b0;
                        araddr  <= pc;
                        inst_pc <= pc;
                        if (pc[1:0] != 2'b00) begin
                            // Misaligned: skip the bus entirely and report an error.
                            inst      <= '0;
                            fetch_err <= 1'b1;
                            state     <= S_OUT;
                        end else begin
                            fetch_err <= 1'b0;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (arready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rvalid) begin
                        inst      <= rdata;
                        fetch_err <= (rresp != 2'b00);
                        state     <= S_OUT;
                    end
                end
                default: begin
                    // S_OUT: fetch_err stays put until the next fetch latches a new pc.
                    if (inst_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Completed-fetch and memory-stall counters; the two increments are independent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (state == S_OUT && inst_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((state == S_REQ && !arready) || (state == S_WAIT && !rvalid)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end

`ifndef SYNTHESIS
    // Trace of each instruction handed to the decoder.
    always_ff @(posedge clk) begin
        if (rst && state == S_OUT && inst_ready) begin
            $display("[IFU] pc=%h inst=%h", inst_pc, inst);
        end
    end
`endif
`endif

endmodule

// File: doc/ysyx_20020207_ifu.md
Name: ysyx_20020207_ifu

Overview:
Instruction fetch unit; the consumer side of the PC register. Takes the current pc and a fetch trigger from writeback, issues one read on a simple AXI-lite-style AR/R channel, and presents the fetched instruction to the decoder over a valid/ready handshake. Exactly one fetch is outstanding at a time, which fits the multi-cycle core.

Parameters:
DATA_WIDTH, 32, width of pc, address, data and instruction.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous reset, active-low (0 = reset).
fetch_en  input  1  pulse from writeback: pc has been updated, start the next fetch.
pc  input  DATA_WIDTH  current program counter.
arvalid  output  1  read address valid.
arready  input  1  read address accepted.
araddr  output  DATA_WIDTH  read address.
rvalid  input  1  read data valid.
rready  output  1  ready to accept read data.
rdata  input  DATA_WIDTH  read data.
rresp  input  2  read response; 2'b00 = OKAY, anything else = error.
inst_valid  output  1  instruction valid to decoder.
inst_ready  input  1  decoder accepts instruction.
inst  output  DATA_WIDTH  fetched instruction.
inst_pc  output  DATA_WIDTH  address the instruction was fetched from.
fetch_err  output  1  qualifies inst; bus error or misaligned pc.
busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, REQ, WAIT, OUT.
- Reset (rst=0, async): state=IDLE; boot=1; arvalid=0, rready=0, inst_valid=0, fetch_err=0; araddr, inst and inst_pc all 0; busy=0.
- IDLE:
  - Leaves on (fetch_en | boot). pc is latched into araddr/inst_pc and boot is cleared.
  - If pc[1:0]!=0: go to OUT with inst=0, fetch_err=1; no bus request is made.
  - Otherwise go to REQ.
  - So the first fetch starts on the first clock after reset release without needing fetch_en.
- REQ: arvalid=1; araddr held stable. On the edge where arvalid & arready, go to WAIT. arvalid is never withdrawn before acceptance.
- WAIT: rready=1, arvalid=0. On rvalid:
  - inst<=rdata.
  - fetch_err<=(rresp!=0).
  - Go to OUT.
  - rvalid seen while in REQ is ignored, since rready=0 there.
- OUT: inst_valid=1; inst, inst_pc and fetch_err are held stable. On inst_valid & inst_ready, go to IDLE; fetch_err is held until the next fetch latch.
- Minimum latency, fetch_en to inst_valid, with zero-wait memory (arready high in REQ, rvalid in the first WAIT cycle): 3 cycles (IDLE→REQ→WAIT→OUT).
- fetch_en outside IDLE: ignored, not queued. Writeback must wait for busy=0.
- fetch_en and boot together: a single fetch.
- Reset mid-transaction: immediate abort to the reset state. The memory slave is reset by the same rst; no response is awaited.
- pc changing after the latch has no effect on the fetch in flight.

Optional Feature:
IFU_PERF_CNT_EN:
- When defined, adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on each OUT handshake.
  - perf_stall_cnt increments on each cycle in REQ with arready=0, or in WAIT with rvalid=0.
  - Both reset to 0, wrap modulo 2^32, and the two increments are independent.
  - On each OUT handshake, the block $display's inst_pc and inst in simulation.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
1. Boot, zero-wait memory returning 0x00000413 at pc=0x20000000 → arvalid at cycle 1 after reset release, araddr=0x20000000; inst_valid at cycle 3 with inst=0x00000413, inst_pc=0x20000000, fetch_err=0.
2. arready delayed 3 cycles, rvalid delayed 2 → arvalid held 4 cycles with constant araddr; rready only in WAIT; inst_valid 1 cycle after rvalid; perf_stall_cnt=5 when IFU_PERF_CNT_EN is defined.
3. rresp=2'b10, rdata=0xDEADBEEF → inst=0xDEADBEEF, fetch_err=1; next fetch with OKAY clears fetch_err.
4. fetch_en with pc=0x20000002 → no arvalid; inst_valid after 1 cycle with inst=0, fetch_err=1.
5. inst_ready low for 4 cycles, fetch_en pulsed while in OUT → inst held stable, the pulse is dropped, no new arvalid after the handshake until the next fetch_en.
6. rst asserted while in WAIT → all outputs go to reset values asynchronously; after release a fresh boot fetch occurs; perf counters=0.
